// File: rtl/seg_chase_decoder.sv
// seg_chase_decoder
// Recovers the chase position of a seven-segment chase/fade LED driver from
// its (possibly PWM-faded, possibly active-low) segment lines.
//
// Operation: each measurement window of 2^WIN_WIDTH clocks counts how many
// cycles every segment was lit. The segment with the strictly highest nonzero
// count is the head. Head changes are mapped onto the eight-state figure-8
// path to track position, direction, lock and step period.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high
//   seg_in     segment lines a..g (bit 0 = segment 0), asynchronous
//   invert     1 = segment lines are active-low, asynchronous
//   pos        reconstructed chase state 0..7
//   pos_valid  pos is known
//   dir        1 = pos incrementing, 0 = decrementing
//   locked     LOCK_STEPS consecutive steps in one direction seen
//   step_stb   one-cycle pulse on an accepted adjacent step
//   err_stb    one-cycle pulse on a non-adjacent jump
//   period     clocks between the last two step_stb pulses
module seg_chase_decoder #(
  parameter int unsigned WIN_WIDTH    = 6,
  parameter int unsigned PERIOD_WIDTH = 16,
  parameter int unsigned LOCK_STEPS   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg_in,
  input  logic                    invert,
  output logic [2:0]              pos,
  output logic                    pos_valid,
  output logic                    dir,
  output logic                    locked,
  output logic                    step_stb,
  output logic                    err_stb,
  output logic [PERIOD_WIDTH-1:0] period
);

  localparam int unsigned NUM_SEG = 7;
  localparam int unsigned CNT_W   = WIN_WIDTH + 1;
  localparam int unsigned CONS_W  = (LOCK_STEPS < 1) ? 1 : $clog2(LOCK_STEPS + 1);
  localparam logic [CONS_W-1:0] CONS_SAT =
    (LOCK_STEPS < 1) ? CONS_W'(1) : CONS_W'(LOCK_STEPS);
  localparam logic [2:0] SEG_AMBIG = 3'd6;

  typedef enum logic {
    S_IDLE,
    S_TRACK
  } state_t;

  // Segment index to path state; segment 6 is resolved separately.
  function automatic logic [2:0] seg_state(input logic [2:0] s);
    case (s)
      3'd0:    return 3'd0;
      3'd1:    return 3'd1;
      3'd2:    return 3'd5;
      3'd3:    return 3'd4;
      3'd4:    return 3'd3;
      3'd5:    return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronizer; invert travels with the segment lines
  // ---------------------------------------------------------------------------
  logic [7:0]         sync1;
  logic [7:0]         sync2;
  logic [NUM_SEG-1:0] lit;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {invert, seg_in};
      sync2 <= sync1;
    end
  end

  assign lit = sync2[6:0] ^ {NUM_SEG{sync2[7]}};

  // ---------------------------------------------------------------------------
  // Measurement window: per-segment on-time counters and snapshot
  // ---------------------------------------------------------------------------
  logic [WIN_WIDTH-1:0] win_cnt;
  logic                 win_last;
  logic [CNT_W-1:0]     on_cnt [NUM_SEG];
  logic [CNT_W-1:0]     snap   [NUM_SEG];
  logic                 snap_valid;

  assign win_last = &win_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt    <= '0;
      snap_valid <= 1'b0;
      for (int unsigned i = 0; i < NUM_SEG; i++) begin
        on_cnt[i] <= '0;
        snap[i]   <= '0;
      end
    end else begin
      win_cnt    <= win_cnt + WIN_WIDTH'(1);
      snap_valid <= win_last;
      for (int unsigned i = 0; i < NUM_SEG; i++) begin
        // The last sample of the window goes straight into the snapshot.
        if (win_last) begin
          snap[i]   <= on_cnt[i] + CNT_W'(lit[i]);
          on_cnt[i] <= '0;
        end else begin
          on_cnt[i] <= on_cnt[i] + CNT_W'(lit[i]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Head selection: strictly brightest nonzero segment, else blank window
  // ---------------------------------------------------------------------------
  logic [2:0] head;
  logic       head_ok;
  logic       beats;

  always_comb begin
    head    = '0;
    head_ok = 1'b0;
    beats   = 1'b0;
    for (int unsigned i = 0; i < NUM_SEG; i++) begin
      beats = (snap[i] != '0);
      for (int unsigned j = 0; j < NUM_SEG; j++) begin
        if (j != i && snap[i] <= snap[j]) begin
          beats = 1'b0;
        end
      end
      if (beats) begin
        head    = 3'(i);
        head_ok = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Step classification against the previous head / position
  // ---------------------------------------------------------------------------
  state_t                  state;
  logic [2:0]              head_q;
  logic [CONS_W-1:0]       cons;
  logic [CONS_W-1:0]       cons_nxt;
  logic [PERIOD_WIDTH-1:0] period_cnt;
  logic                    have_step;

  logic [2:0] old_state;
  logic [2:0] new_state;
  logic       old_ok;
  logic       new_ok;
  logic       is_inc;
  logic       is_dec;
  logic       head_moved;
  logic       reversal;

  always_comb begin
    old_state = pos;
    old_ok    = pos_valid;
    new_state = seg_state(head);
    new_ok    = 1'b1;

    // Leaving seg6 with pos unknown: infer where seg6 must have been.
    if (!pos_valid) begin
      old_state = 3'd0;
      old_ok    = 1'b0;
      case (head)
        3'd1, 3'd4: begin old_state = 3'd2; old_ok = 1'b1; end
        3'd2, 3'd5: begin old_state = 3'd6; old_ok = 1'b1; end
        default:    ;
      endcase
    end

    // Arriving at seg6: the predecessor picks the upper or lower crossing.
    if (head == SEG_AMBIG) begin
      new_state = 3'd0;
      new_ok    = 1'b0;
      case (head_q)
        3'd1, 3'd4: begin new_state = 3'd2; new_ok = 1'b1; end
        3'd2, 3'd5: begin new_state = 3'd6; new_ok = 1'b1; end
        default:    ;
      endcase
    end

    is_inc     = old_ok && new_ok && (new_state == 3'(old_state + 3'd1));
    is_dec     = old_ok && new_ok && (new_state == 3'(old_state - 3'd1));
    head_moved = snap_valid && head_ok && (head != head_q);

    // A zero run count means no previous direction to compare against.
    reversal = (cons != '0) && (dir != is_inc);
    if (reversal) begin
      cons_nxt = CONS_W'(1);
    end else if (cons >= CONS_SAT) begin
      cons_nxt = CONS_SAT;
    end else begin
      cons_nxt = cons + CONS_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Tracking FSM, outputs and step-period measurement
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      head_q     <= '0;
      cons       <= '0;
      period_cnt <= '0;
      have_step  <= 1'b0;
      pos        <= '0;
      pos_valid  <= 1'b0;
      dir        <= 1'b0;
      locked     <= 1'b0;
      step_stb   <= 1'b0;
      err_stb    <= 1'b0;
      period     <= '0;
    end else begin
      step_stb <= 1'b0;
      err_stb  <= 1'b0;
      if (period_cnt != '1) begin
        period_cnt <= period_cnt + PERIOD_WIDTH'(1);
      end

      case (state)
        S_IDLE: begin
          if (snap_valid && head_ok) begin
            state      <= S_TRACK;
            head_q     <= head;
            pos_valid  <= (head != SEG_AMBIG);
            if (head != SEG_AMBIG) begin
              pos <= seg_state(head);
            end
            // Restart the timeout from the seed; no period until a real step.
            period_cnt <= PERIOD_WIDTH'(1);
            have_step  <= 1'b0;
            cons       <= '0;
            locked     <= 1'b0;
          end
        end

        S_TRACK: begin
          if (head_moved) begin
            head_q <= head;
            if (is_inc || is_dec) begin
              pos        <= new_state;
              pos_valid  <= 1'b1;
              dir        <= is_inc;
              step_stb   <= 1'b1;
              period_cnt <= PERIOD_WIDTH'(1);
              have_step  <= 1'b1;
              if (have_step) begin
                period <= period_cnt;
              end
              cons   <= cons_nxt;
              locked <= (cons_nxt >= CONS_SAT) && !reversal;
            end else begin
              // Non-adjacent jump: re-seed from the new head.
              err_stb   <= 1'b1;
              locked    <= 1'b0;
              cons      <= '0;
              pos_valid <= (head != SEG_AMBIG);
              if (head != SEG_AMBIG) begin
                pos <= seg_state(head);
              end
            end
          end else if (period_cnt == '1) begin
            // No step for a full period-counter range: lose track.
            state     <= S_IDLE;
            pos_valid <= 1'b0;
            locked    <= 1'b0;
            cons      <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_chase_decoder.sv
// Testbench for seg_chase_decoder (WIN_WIDTH=4, PERIOD_WIDTH=8, LOCK_STEPS=2).
// Each table record describes one 16-clock window of segment activity and the
// outputs expected after that window; expectations are queued when a window
// is driven and compared when the decoder reports that window.
module tb_seg_chase_decoder;

  localparam int unsigned WW  = 4;
  localparam int unsigned PW  = 8;
  localparam int unsigned LS  = 2;
  localparam int          WIN = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [6:0]    seg_in = '0;
  logic          invert = 1'b0;
  logic [2:0]    pos;
  logic          pos_valid;
  logic          dir;
  logic          locked;
  logic          step_stb;
  logic          err_stb;
  logic [PW-1:0] period;

  always #5 clk = ~clk;

  seg_chase_decoder #(
    .WIN_WIDTH   (WW),
    .PERIOD_WIDTH(PW),
    .LOCK_STEPS  (LS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .seg_in   (seg_in),
    .invert   (invert),
    .pos      (pos),
    .pos_valid(pos_valid),
    .dir      (dir),
    .locked   (locked),
    .step_stb (step_stb),
    .err_stb  (err_stb),
    .period   (period)
  );

  typedef struct {
    logic [2:0] hseg;
    int         hduty;
    logic [2:0] tseg;
    int         tduty;
    bit         inv;
    logic [2:0] pos;
    bit         pv;
    bit         dir;
    bit         lk;
    bit         stp;
    bit         err;
    logic [7:0] per;
  } vec_t;

  typedef struct {
    string      tag;
    logic [2:0] pos;
    bit         pv;
    bit         dir;
    bit         lk;
    bit         stp;
    bit         err;
    logic [7:0] per;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   win_no = 0;

  function automatic vec_t mk(input logic [2:0] hs, input int hd,
                              input logic [2:0] ts, input int td, input bit inv,
                              input logic [2:0] p, input bit pv, input bit dr,
                              input bit lk, input bit st, input bit er,
                              input logic [7:0] pr);
    vec_t v;
    v.hseg = hs; v.hduty = hd; v.tseg = ts; v.tduty = td; v.inv = inv;
    v.pos = p; v.pv = pv; v.dir = dr; v.lk = lk; v.stp = st; v.err = er;
    v.per = pr;
    return v;
  endfunction

  function automatic exp_t zero_exp(input string tag);
    exp_t e;
    e.tag = tag; e.pos = 3'd0; e.pv = 1'b0; e.dir = 1'b0; e.lk = 1'b0;
    e.stp = 1'b0; e.err = 1'b0; e.per = 8'd0;
    return e;
  endfunction

  // pos is only compared when it is expected to be valid.
  task automatic check_out(input exp_t e);
    bit bad;
    checks++;
    bad = (pos_valid !== e.pv) || (e.pv && (pos !== e.pos)) ||
          (dir !== e.dir) || (locked !== e.lk) || (step_stb !== e.stp) ||
          (err_stb !== e.err) || (period !== e.per);
    if (bad) begin
      errors++;
      $display("FAIL %s: got pos=%0d pv=%0b dir=%0b lk=%0b stp=%0b err=%0b per=%0d, want pos=%0d pv=%0b dir=%0b lk=%0b stp=%0b err=%0b per=%0d",
               e.tag, pos, pos_valid, dir, locked, step_stb, err_stb, period,
               e.pos, e.pv, e.dir, e.lk, e.stp, e.err, e.per);
    end
  endtask

  // Hold reset, check the reset state, release aligned to window 0 (blank).
  task automatic reset_seq();
    reset  = 1'b1;
    seg_in = '0;
    invert = 1'b0;
    repeat (3) @(negedge clk);
    check_out(zero_exp("reset"));
    reset  = 1'b0;
    sb.push_back(zero_exp("win0"));
    win_no = 1;
    repeat (WIN - 2) @(negedge clk);
  endtask

  // Drive one window; the previous window's result appears mid-way through.
  task automatic apply_window(input vec_t v);
    exp_t       e;
    logic [6:0] bits;
    e.tag = $sformatf("win%0d", win_no);
    e.pos = v.pos; e.pv = v.pv; e.dir = v.dir; e.lk = v.lk;
    e.stp = v.stp; e.err = v.err; e.per = v.per;
    sb.push_back(e);
    win_no++;
    for (int j = 0; j < WIN; j++) begin
      bits = '0;
      if (j < v.hduty) bits[v.hseg] = 1'b1;
      if (j < v.tduty) bits[v.tseg] = 1'b1;
      invert = v.inv;
      seg_in = v.inv ? ~bits : bits;
      @(negedge clk);
      if (j == 2 && sb.size() > 0) check_out(sb.pop_front());
    end
  endtask

  task automatic drain();
    repeat (3) @(negedge clk);
    while (sb.size() > 0) check_out(sb.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1);
  end

  initial begin
    logic [2:0] fh [9];
    fh = '{3'd0, 3'd1, 3'd6, 3'd4, 3'd3, 3'd2, 3'd6, 3'd5, 3'd0};

    // Forward chase, each head held for two windows (32 clocks).
    for (int i = 0; i < 9; i++) begin
      tbl.push_back(mk(fh[i], 16, 3'd0, 0, 1'b0, 3'(i), 1'b1, i > 0, i >= 2,
                       i > 0, 1'b0, (i >= 2) ? 8'd32 : 8'd0));
      tbl.push_back(mk(fh[i], 16, 3'd0, 0, 1'b0, 3'(i), 1'b1, i > 0, i >= 2,
                       1'b0, 1'b0, (i >= 2) ? 8'd32 : 8'd0));
    end
    // Locked at pos 1, then a jump to seg3 and a recovery step.
    tbl.push_back(mk(3'd1, 16, 3'd0, 0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd32));
    tbl.push_back(mk(3'd3, 16, 3'd0, 0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd32));
    tbl.push_back(mk(3'd2, 16, 3'd0, 0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd32));
    // Inverted lines: up to 7, then reverse seg5 -> seg6 -> seg2.
    tbl.push_back(mk(3'd6, 16, 3'd0, 0, 1'b1, 3'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd16));
    tbl.push_back(mk(3'd5, 16, 3'd0, 0, 1'b1, 3'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd16));
    tbl.push_back(mk(3'd6, 16, 3'd0, 0, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd16));
    tbl.push_back(mk(3'd2, 16, 3'd0, 0, 1'b1, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd16));
    // Fade tail 12/16 vs 6/16, then an 8/8 tie (blank), then fade again.
    tbl.push_back(mk(3'd3, 12, 3'd2, 6, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd16));
    tbl.push_back(mk(3'd3, 8,  3'd4, 8, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd16));
    tbl.push_back(mk(3'd4, 12, 3'd3, 6, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd32));
    // Dark display: still tracking after 240 clocks, timed out after 256.
    for (int i = 0; i < 15; i++) begin
      tbl.push_back(mk(3'd0, 0, 3'd0, 0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd32));
    end
    tbl.push_back(mk(3'd0, 0, 3'd0, 0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd32));
    // Seg6 first from IDLE, then seg2 resolves it to 6 -> 5.
    tbl.push_back(mk(3'd6, 16, 3'd0, 0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd32));
    tbl.push_back(mk(3'd2, 16, 3'd0, 0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd32));

    reset_seq();
    foreach (tbl[i]) apply_window(tbl[i]);
    drain();

    // Reset in the middle of a partially lit window.
    seg_in = 7'b0000010;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_out(zero_exp("mid_reset"));
    reset_seq();
    apply_window(mk(3'd0, 16, 3'd0, 0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
